// File: rtl/instr_fetch_unit_if.sv
// Fetch bus: combinational instruction-memory read port plus the valid/ready stage toward decode.
// The master (fetch unit) drives the read address and the output entry. The slave returns the word and ready.
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
);
    logic [ADDR_W-1:0]  Read_Address;
    logic [INSTR_W-1:0] instruction;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output Read_Address, out_instr, out_pc, out_valid,
        input  instruction, out_ready
    );

    modport slave (
        input  Read_Address, out_instr, out_pc, out_valid,
        output instruction, out_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Purpose: PC owner and fetch FSM; registers each memory word with its PC for decode. JUMP_PREDECODE_EN resolves 2'b11 jumps here.
// Latency: start at N, Read_Address=0 at N+1, first out_valid at N+2; one word per cycle when out_ready is held high.
// Backpressure: a held entry (out_valid & !out_ready) freezes out_* and pc; the next capture happens on the accept cycle.
module instr_fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 8,
    parameter int PROG_LEN = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               halted,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    // One extra bit so PROG_LEN == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] PROG_END = (ADDR_W+1)'(PROG_LEN);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, next_pc;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  opc_q, opc_d;
    logic               valid_q, valid_d;
    logic               capture;

    always_comb begin
        next_pc = pc_q + ADDR_W'(1);
`ifdef JUMP_PREDECODE_EN
        if (bus.instruction[7:6] == 2'b11)
            next_pc = pc_q + ADDR_W'(1)
                    + {{(ADDR_W-6){bus.instruction[5]}}, bus.instruction[5:0]};
`endif
    end

    assign capture = (state_q == FETCH) && (!valid_q || bus.out_ready);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        valid_d = valid_q;

        // A pending entry drains in every state; a same-cycle capture overrides the pop.
        if (valid_q && bus.out_ready)
            valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            FETCH: begin
                if (capture) begin
                    instr_d = bus.instruction;
                    opc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = next_pc;
                    if ({1'b0, next_pc} >= PROG_END)
                        state_d = HALT;
                end
            end
            HALT: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            opc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Read_Address = pc_q;
    assign bus.out_instr    = instr_q;
    assign bus.out_pc       = opc_q;
    assign bus.out_valid    = valid_q;
    assign halted           = (state_q == HALT);
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side initiator for the combinational 8-bit instruction memory.
- Owns the program counter and drives the memory read address.
- Registers each returned instruction, with its PC, into a valid/ready output stage that feeds decode.
- Resolves unconditional jumps (opcode 2'b11) locally and halts at end of program.

Parameters:
- ADDR_W, 8, PC / read-address width.
- INSTR_W, 8, instruction width.
- PROG_LEN, 32, number of valid instruction words; PC >= PROG_LEN ends the program.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins fetching from PC 0.
- Read_Address  output  ADDR_W  address to instruction memory; equals pc, combinational from the register.
- instruction  input  INSTR_W  word returned by memory in the same cycle.
- out_instr  output  INSTR_W  registered instruction to decode.
- out_pc  output  ADDR_W  PC of out_instr.
- out_valid  output  1  out_instr/out_pc hold a valid entry.
- out_ready  input  1  decode accepts the entry this cycle.
- halted  output  1  fetch finished; high in HALT state.

Behaviour:
- Reset (synchronous, highest priority, any state): state=IDLE, pc=0, out_instr=0, out_pc=0, out_valid=0, halted=0.
- States: IDLE, FETCH, HALT.
- IDLE: Read_Address=pc. On start=1, go to FETCH with pc=0.
- FETCH, capture condition: capture when out_valid=0 or (out_valid & out_ready). On capture:
  - out_instr<=instruction, out_pc<=pc, out_valid<=1.
  - next_pc = pc+1, mod 2^ADDR_W.
  - If instruction[7:6]==2'b11 (with predecode on): next_pc = pc+1+sext(instruction[5:0]), 8-bit wrap.
  - The jump word itself is still emitted to decode.
- FETCH, end of program: if next_pc >= PROG_LEN, go to HALT instead of updating further; pc<=next_pc.
- FETCH, no capture: pc, out_* and state hold.
- Backpressure: while out_valid=1 and out_ready=0, out_instr/out_pc are stable and pc does not advance.
- Output pop: out_valid drops to 0 on an accept cycle only if no new capture happens that cycle.
- HALT:
  - halted=1; no captures.
  - The already-registered entry stays valid until accepted; out_valid then goes 0.
  - start=1 returns to FETCH with pc=0, halted=0.
  - A pending entry still drains normally and is not discarded.
- start during FETCH: ignored.
- Latency: start at cycle N → FETCH at N+1 with Read_Address=0 → out_valid=1 at N+2.
- Throughput: with out_ready held 1, one instruction per cycle.
- Jump arithmetic: offset is instruction[5:0] sign-extended to ADDR_W, giving a range of −32..+31 relative to pc+1. Wrap-around is modulo 256; a target >= PROG_LEN halts.

Optional Feature:
- JUMP_PREDECODE_EN defined: jumps are redirected in fetch as described above.
- Undefined: no opcode inspection. next_pc is always pc+1; jumps pass through as ordinary words and decode must redirect. The halt rule still applies to pc+1.

Test Plan:
- Memory contents: mem[0..4] = 0x49, 0xC1, 0x18, 0xA9, 0x4D.
- Straight-line fetch: PROG_LEN=5, JUMP_PREDECODE_EN undefined, reset, start, out_ready=1 → (out_pc,out_instr) = (0,0x49), (1,0xC1), (2,0x18), (3,0xA9), (4,0x4D) on consecutive cycles from N+2. Then halted=1 and out_valid=0 after the last accept.
- Jump redirect: same program, JUMP_PREDECODE_EN defined → (0,0x49), (1,0xC1), (3,0xA9), (4,0x4D); PC 2 is never emitted; then halted=1.
- Backpressure: out_ready=0 for 3 cycles after first valid → out_pc=0 and out_instr=0x49 stable, Read_Address=1 throughout. Release → next entry is (1,0xC1) one cycle later, with no loss or duplication.
- Jump out of range: mem[1]=0xDF (offset +31, target 33), PROG_LEN=32, predecode on → 0xDF emitted, then HALT, halted=1, no further captures.
- Reset mid-operation: assert reset for 1 cycle while out_valid=1 at pc=3 → next cycle out_valid=0, out_pc=0, out_instr=0, pc=0, state IDLE. No fetch occurs until a new start.
- Restart from HALT: pulse start while halted=1 → halted=0 next cycle, and the sequence repeats from (0,0x49).
